serv_decode_queue: RTL and testbench

- Buffered, parametrised successor to the single-instruction SERV decoder.
- Accepts raw instruction words from the ibus side into a DEPTH-entry FIFO.
- Decodes the head entry into a registered control bundle, which it presents to the state/ctrl logic over a valid/ready handshake.
- Lets fetch run ahead of the bit-serial core and supports pipeline flush on taken branch or trap.

---
 rtl/serv_decode_queue_if.sv | 47 ++++
 rtl/serv_decode_queue.sv | 136 +++++++++++++
 tb/tb_serv_decode_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serv_decode_queue_if.sv
// Fetch/consumer-side bundle for serv_decode_queue. o_illegal and i_wb_rdt_lo
// exist only when SERV_DECODE_ILLEGAL_EN is defined.
interface serv_decode_queue_if #(parameter int DEPTH = 2);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [29:0]   i_wb_rdt;
  logic          i_wb_en;
  logic          o_wb_rdy;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [4:0]    o_opcode;
  logic [2:0]    o_funct3;
  logic [4:0]    o_rd_addr;
  logic [4:0]    o_rs1_addr;
  logic [4:0]    o_rs2_addr;
  logic          o_rd_op;
  logic          o_two_stage_op;
  logic          o_branch_op;
  logic          o_dbus_en;
  logic          o_mem_cmd;
  logic          o_csr_op;
  logic          o_mdu_op;
  logic [CW-1:0] o_count;
`ifdef SERV_DECODE_ILLEGAL_EN
  logic [1:0]    i_wb_rdt_lo;
  logic          o_illegal;

  modport master (output i_wb_rdt, i_wb_en, i_flush, i_ready, i_wb_rdt_lo,
                  input  o_wb_rdy, o_valid, o_opcode, o_funct3, o_rd_addr, o_rs1_addr,
                         o_rs2_addr, o_rd_op, o_two_stage_op, o_branch_op, o_dbus_en,
                         o_mem_cmd, o_csr_op, o_mdu_op, o_count, o_illegal);
  modport slave  (input  i_wb_rdt, i_wb_en, i_flush, i_ready, i_wb_rdt_lo,
                  output o_wb_rdy, o_valid, o_opcode, o_funct3, o_rd_addr, o_rs1_addr,
                         o_rs2_addr, o_rd_op, o_two_stage_op, o_branch_op, o_dbus_en,
                         o_mem_cmd, o_csr_op, o_mdu_op, o_count, o_illegal);
`else
  modport master (output i_wb_rdt, i_wb_en, i_flush, i_ready,
                  input  o_wb_rdy, o_valid, o_opcode, o_funct3, o_rd_addr, o_rs1_addr,
                         o_rs2_addr, o_rd_op, o_two_stage_op, o_branch_op, o_dbus_en,
                         o_mem_cmd, o_csr_op, o_mdu_op, o_count);
  modport slave  (input  i_wb_rdt, i_wb_en, i_flush, i_ready,
                  output o_wb_rdy, o_valid, o_opcode, o_funct3, o_rd_addr, o_rs1_addr,
                         o_rs2_addr, o_rd_op, o_two_stage_op, o_branch_op, o_dbus_en,
                         o_mem_cmd, o_csr_op, o_mdu_op, o_count);
`endif
endinterface

// File: rtl/serv_decode_queue.sv
// DEPTH-entry instruction FIFO feeding a registered SERV decode bundle over valid/ready.
// Define SERV_DECODE_ILLEGAL_EN to add the o_illegal flag (stored per FIFO entry).
module serv_decode_queue #(
  parameter int DEPTH = 2,
  parameter int MDU   = 0,
  parameter int W     = 32
) (
  input logic clk,
  input logic i_rst_n,
  serv_decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef SERV_DECODE_ILLEGAL_EN
  localparam int EW = W - 1;
`else
  localparam int EW = W - 2;
`endif

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_op;
    logic       two_stage;
    logic       branch;
    logic       dbus_en;
    logic       mem_cmd;
    logic       csr_op;
    logic       mdu_op;
`ifdef SERV_DECODE_ILLEGAL_EN
    logic       illegal;
`endif
  } dec_t;

  // Entry bit i holds instruction bit i+2; the top bit (if present) flags bad low bits.
  function automatic dec_t decode(input logic [EW-1:0] e);
    dec_t       d;
    logic [4:0] op;
    logic [2:0] f3;
    logic       mdu;
    op  = e[4:0];
    f3  = e[12:10];
    mdu = (MDU != 0) && (op == 5'b01100) && e[23];
    d.opcode    = op;
    d.funct3    = f3;
    d.rd        = e[9:5];
    d.rs1       = e[17:13];
    d.rs2       = e[22:18];
    d.two_stage = !op[2] | (f3[0] & !f3[1] & !op[0] & !op[4])
                | (f3[1] & !f3[2] & !op[0] & !op[4]) | mdu;
    d.rd_op     = op[2] | (!op[2] & op[4] & op[0]) | (!op[2] & !op[3] & !op[0]);
    d.branch    = op[4];
    d.dbus_en   = !op[2] & !op[4];
    d.mem_cmd   = op[3] & !op[2] & !op[4];
    d.csr_op    = op[4] & op[2] & (|f3);
    d.mdu_op    = mdu;
`ifdef SERV_DECODE_ILLEGAL_EN
    d.illegal   = e[EW-1] | !(op inside {5'b00000, 5'b00011, 5'b00100, 5'b00101,
                                         5'b01000, 5'b01100, 5'b01101, 5'b11000,
                                         5'b11001, 5'b11011, 5'b11100});
`endif
    return d;
  endfunction

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  dec_t          r_dec;

  logic [EW-1:0] w_entry;
  logic          w_push, w_load, w_pop, w_bypass, w_wr;

`ifdef SERV_DECODE_ILLEGAL_EN
  assign w_entry = {(bus.i_wb_rdt_lo != 2'b11), bus.i_wb_rdt};
`else
  assign w_entry = bus.i_wb_rdt;
`endif

  assign bus.o_wb_rdy = (r_count != CW'(DEPTH));
  assign w_push   = bus.i_wb_en & bus.o_wb_rdy & !bus.i_flush;
  assign w_load   = !r_valid | bus.i_ready;
  assign w_pop    = w_load & (r_count != '0);
  // Empty queue and a free output register: skip the FIFO for 1-cycle latency.
  assign w_bypass = w_load & (r_count == '0) & w_push;
  assign w_wr     = w_push & !w_bypass;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_dec   <= '0;
    end else if (bus.i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_load) begin
        r_valid <= w_pop | w_bypass;
        if (w_pop)         r_dec <= decode(r_mem[r_rptr]);
        else if (w_bypass) r_dec <= decode(w_entry);
      end
    end
  end

  assign bus.o_valid        = r_valid;
  assign bus.o_count        = r_count;
  assign bus.o_opcode       = r_dec.opcode;
  assign bus.o_funct3       = r_dec.funct3;
  assign bus.o_rd_addr      = r_dec.rd;
  assign bus.o_rs1_addr     = r_dec.rs1;
  assign bus.o_rs2_addr     = r_dec.rs2;
  assign bus.o_rd_op        = r_dec.rd_op;
  assign bus.o_two_stage_op = r_dec.two_stage;
  assign bus.o_branch_op    = r_dec.branch;
  assign bus.o_dbus_en      = r_dec.dbus_en;
  assign bus.o_mem_cmd      = r_dec.mem_cmd;
  assign bus.o_csr_op       = r_dec.csr_op;
  assign bus.o_mdu_op       = r_dec.mdu_op;
`ifdef SERV_DECODE_ILLEGAL_EN
  assign bus.o_illegal      = r_dec.illegal;
`endif
endmodule

// File: tb/tb_serv_decode_queue.sv
// Directed bench for serv_decode_queue: two instances (MDU=0, MDU=1) share one stimulus.
module tb_serv_decode_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serv_decode_queue_if #(.DEPTH(2)) bus0 ();
  serv_decode_queue_if #(.DEPTH(2)) bus1 ();

  assign bus1.i_wb_rdt = bus0.i_wb_rdt;
  assign bus1.i_wb_en  = bus0.i_wb_en;
  assign bus1.i_flush  = bus0.i_flush;
  assign bus1.i_ready  = bus0.i_ready;
`ifdef SERV_DECODE_ILLEGAL_EN
  assign bus1.i_wb_rdt_lo = bus0.i_wb_rdt_lo;
`endif

  serv_decode_queue #(.DEPTH(2), .MDU(0), .W(32)) dut0 (.clk(clk), .i_rst_n(rst_n), .bus(bus0));
  serv_decode_queue #(.DEPTH(2), .MDU(1), .W(32)) dut1 (.clk(clk), .i_rst_n(rst_n), .bus(bus1));

  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] ADDI2 = 32'h00500113;
  localparam logic [31:0] ADDI3 = 32'h00500193;
  localparam logic [31:0] ADDI4 = 32'h00500213;
  localparam logic [31:0] SW    = 32'h00112023;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] MUL   = 32'h02208033;
  localparam logic [31:0] CSRRW = 32'h34011073;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] insn);
    logic [31:0] t;
    t = insn;
    bus0.i_wb_en  = en;
    bus0.i_wb_rdt = t[31:2];
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.i_flush = 1'b0;
    bus0.i_ready = 1'b0;
    drive(1'b0, 32'h0);
`ifdef SERV_DECODE_ILLEGAL_EN
    bus0.i_wb_rdt_lo = 2'b11;
`endif
    #12;
    chk("rst_valid", bus0.o_valid, 0);
    chk("rst_count", bus0.o_count, 0);
    chk("rst_rdy", bus0.o_wb_rdy, 1);
    chk("rst_opcode", bus0.o_opcode, 0);
    chk("rst_rd_op", bus0.o_rd_op, 0);
    #5 rst_n = 1'b1;

    // single addi, bypass path
    bus0.i_ready = 1'b1;
    drive(1'b1, ADDI1);
    tick();
    chk("addi_valid", bus0.o_valid, 1);
    chk("addi_opcode", bus0.o_opcode, 5'b00100);
    chk("addi_rd", bus0.o_rd_addr, 1);
    chk("addi_rd_op", bus0.o_rd_op, 1);
    chk("addi_two_stage", bus0.o_two_stage_op, 0);
    chk("addi_count", bus0.o_count, 0);
`ifdef SERV_DECODE_ILLEGAL_EN
    chk("addi_illegal", bus0.o_illegal, 0);
`endif
    drive(1'b0, 32'h0);
    tick();
    chk("addi_drain_valid", bus0.o_valid, 0);
    chk("addi_drain_count", bus0.o_count, 0);

    // fill while stalled, then drain in order
    bus0.i_ready = 1'b0;
    drive(1'b1, ADDI1); tick();
    drive(1'b1, ADDI2); tick();
    drive(1'b1, ADDI3); tick();
    drive(1'b0, 32'h0);
    chk("fill_valid", bus0.o_valid, 1);
    chk("fill_rd0", bus0.o_rd_addr, 1);
    chk("fill_count", bus0.o_count, 2);
    chk("fill_rdy", bus0.o_wb_rdy, 0);
    tick();
    chk("stall_hold_rd", bus0.o_rd_addr, 1);
    bus0.i_ready = 1'b1;
    tick();
    chk("drain_rd1", bus0.o_rd_addr, 2);
    chk("drain_count1", bus0.o_count, 1);
    tick();
    chk("drain_rd2", bus0.o_rd_addr, 3);
    chk("drain_count0", bus0.o_count, 0);
    chk("drain_valid2", bus0.o_valid, 1);
    tick();
    chk("drain_empty", bus0.o_valid, 0);

    // decode vectors, back-to-back bypass
`ifdef SERV_DECODE_ILLEGAL_EN
    bus0.i_wb_rdt_lo = 2'b01;
`endif
    drive(1'b1, SW); tick();
    chk("sw_dbus_en", bus0.o_dbus_en, 1);
    chk("sw_mem_cmd", bus0.o_mem_cmd, 1);
    chk("sw_rd_op", bus0.o_rd_op, 0);
    chk("sw_two_stage", bus0.o_two_stage_op, 1);
    chk("sw_rs1", bus0.o_rs1_addr, 2);
    chk("sw_rs2", bus0.o_rs2_addr, 1);
`ifdef SERV_DECODE_ILLEGAL_EN
    chk("sw_illegal_lo", bus0.o_illegal, 1);
    bus0.i_wb_rdt_lo = 2'b11;
`endif
    drive(1'b1, BEQ); tick();
    chk("beq_branch", bus0.o_branch_op, 1);
    chk("beq_two_stage", bus0.o_two_stage_op, 1);
    chk("beq_rd_op", bus0.o_rd_op, 0);
    chk("beq_dbus_en", bus0.o_dbus_en, 0);
    drive(1'b1, MUL); tick();
    chk("mul_mdu0", bus0.o_mdu_op, 0);
    chk("mul_two_stage0", bus0.o_two_stage_op, 0);
    chk("mul_mdu1", bus1.o_mdu_op, 1);
    chk("mul_two_stage1", bus1.o_two_stage_op, 1);
    chk("mul_rd_op", bus1.o_rd_op, 1);
    drive(1'b1, CSRRW); tick();
    chk("csr_op", bus0.o_csr_op, 1);
    chk("csr_funct3", bus0.o_funct3, 3'b001);
    chk("csr_rd_op", bus0.o_rd_op, 1);
    chk("csr_two_stage", bus0.o_two_stage_op, 0);
    drive(1'b0, 32'h0); tick();
    chk("vec_empty", bus0.o_valid, 0);

    // push and pop in the same cycle with count>0
    bus0.i_ready = 1'b0;
    drive(1'b1, ADDI1); tick();
    drive(1'b1, ADDI2); tick();
    bus0.i_ready = 1'b1;
    drive(1'b1, ADDI3); tick();
    chk("pp_rd", bus0.o_rd_addr, 2);
    chk("pp_count", bus0.o_count, 1);
    drive(1'b0, 32'h0); tick();
    chk("pp_rd_next", bus0.o_rd_addr, 3);
    chk("pp_count_next", bus0.o_count, 0);
    tick();
    chk("pp_empty", bus0.o_valid, 0);

    // flush with a simultaneous push
    bus0.i_ready = 1'b0;
    drive(1'b1, ADDI1); tick();
    drive(1'b1, ADDI2); tick();
    drive(1'b1, ADDI3); tick();
    chk("pre_flush_count", bus0.o_count, 2);
    bus0.i_flush = 1'b1;
    bus0.i_ready = 1'b1;
    drive(1'b1, ADDI4); tick();
    chk("flush_valid", bus0.o_valid, 0);
    chk("flush_count", bus0.o_count, 0);
    chk("flush_rdy", bus0.o_wb_rdy, 1);
    bus0.i_flush = 1'b0;
    drive(1'b0, 32'h0); tick();
    chk("flush_no_ghost", bus0.o_valid, 0);
    chk("flush_count2", bus0.o_count, 0);

    // asynchronous reset mid-stream
    bus0.i_ready = 1'b0;
    drive(1'b1, ADDI1); tick();
    drive(1'b1, ADDI2); tick();
    drive(1'b0, 32'h0);
    chk("pre_rst_valid", bus0.o_valid, 1);
    chk("pre_rst_count", bus0.o_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus0.o_valid, 0);
    chk("arst_count", bus0.o_count, 0);
    chk("arst_rd", bus0.o_rd_addr, 0);
    chk("arst_opcode", bus0.o_opcode, 0);
    chk("arst_rd_op", bus0.o_rd_op, 0);
    chk("arst_rdy", bus0.o_wb_rdy, 1);
    #3 rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
